// File: rtl/shift_right_seq_if.sv
// Operand/result handshake bundle for the sequential right shifter.
// The master side issues operands and consumes results; the slave side is the shifter.
interface shift_right_seq_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             arith;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;

  modport master (
    output in_valid,
    input  in_ready,
    output A,
    output B,
    output arith,
    input  out_valid,
    output out_ready,
    input  Y
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  A,
    input  B,
    input  arith,
    output out_valid,
    input  out_ready,
    output Y
  );
endinterface

// File: rtl/shift_right_seq.sv
// Sequential SRL/SRA unit: one radix-2 stage per clock, fixed latency of STAGES cycles,
// valid/ready on both the operand and result side.
module shift_right_seq #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_right_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(STAGES);
  localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(STAGES - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg,   cnt_next;
  logic [WIDTH-1:0]  work_reg,  work_next;
  logic [STAGES-1:0] amt_reg,   amt_next;
  logic              fill_reg,  fill_next;

  logic              accept;
  logic [WIDTH-1:0]  stage_out [STAGES];
  logic [WIDTH-1:0]  stage_sel;
  logic              unused_b;

  // Upper shift-amount bits are architecturally ignored.
  assign unused_b = ^bus.B[WIDTH-1:STAGES];

  assign bus.in_ready  = (state_reg == ST_IDLE);
  assign bus.out_valid = (state_reg == ST_DONE);
  assign bus.Y         = work_reg;

  assign accept = bus.in_valid && (state_reg == ST_IDLE);

  // Candidate result of every stage; the counter picks the one applied this cycle.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      assign stage_out[gi] = amt_reg[gi] ? {{SH{fill_reg}}, work_reg[WIDTH-1:SH]} : work_reg;
    end
  endgenerate

  always_comb begin
    stage_sel = work_reg;
    for (int k = 0; k < STAGES; k++) begin
      if (cnt_reg == CNT_W'(k)) begin
        stage_sel = stage_out[k];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    work_next  = work_reg;
    amt_next   = amt_reg;
    fill_next  = fill_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          work_next  = bus.A;
          amt_next   = bus.B[STAGES-1:0];
          fill_next  = bus.arith & bus.A[WIDTH-1];
          cnt_next   = '0;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Every stage runs even when its amount bit is clear, so latency never varies.
        work_next = stage_sel;
        cnt_next  = cnt_reg + 1'b1;
        if (cnt_reg == LAST_STAGE) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      work_reg  <= '0;
      amt_reg   <= '0;
      fill_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      work_reg  <= work_next;
      amt_reg   <= amt_next;
      fill_reg  <= fill_next;
    end
  end

  // Result must stay put while the consumer stalls.
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.Y)));

  a_no_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.in_ready && bus.out_valid));

endmodule

// File: doc/shift_right_seq.md
# shift_right_seq

Sequential 64-bit right shifter: the right-shift partner to the combinational left-shift unit in the ALU datapath. It supports logical (SRL) and arithmetic (SRA) shifts. It applies one radix-2 stage per clock (shift by 1, 2, 4, 8, 16, 32) and trades latency for area. Operands enter and results leave through valid/ready handshakes so the execute stage can stall on either side.

## Interface
- `WIDTH`, default 64: data width; fixed at 64 for this revision.
- `STAGES`, default 6: number of shift stages, equal to log2(WIDTH); the shift amount is `B[STAGES-1:0]`.
- `clk`, input, 1: rising-edge clock; the only clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: operand request.
- `in_ready`, output, 1: block can accept an operand.
- `A`, input, 64: value to shift.
- `B`, input, 64: shift amount; only `B[5:0]` is used (0-63), `B[63:6]` is ignored.
- `arith`, input, 1: 1 selects SRA (sign fill), 0 selects SRL (zero fill).
- `out_valid`, output, 1: `Y` holds a completed result.
- `out_ready`, input, 1: consumer accepts the result.
- `Y`, output, 64: shift result, registered.

## Operation
- States: IDLE, SHIFT, DONE.
- `in_ready` = (state == IDLE).
- `out_valid` = (state == DONE).
- IDLE: on `in_valid && in_ready`, capture:
  - the working register from `A`,
  - `amt` from `B[5:0]`,
  - `fill` = `arith & A[63]`,
  - stage counter = 0.
  Then go to SHIFT.
- SHIFT, each cycle at stage k:
  - if `amt[k]`, working = {2^k copies of `fill`, working[63:2^k]}; otherwise working is unchanged;
  - counter increments;
  - after stage 5 is applied, go to DONE.
- All 6 stages always run, including when `amt` = 0; latency is fixed.
- DONE: `Y` drives the working register.
  - On `out_ready`, return to IDLE.
  - While `out_ready` is low, `Y` and `out_valid` hold stable.
- Operand inputs are sampled only at the accept edge. Changes to `A`, `B` or `arith` afterwards have no effect on the result.
- An accept is never taken in the same cycle as an output handoff: `in_ready` is 0 in DONE.
- Width rules:
  - SRL by n: `Y` = A >> n, with n zeros in the top bits.
  - SRA by n: the top n bits equal `A[63]`.
  - n = 0 returns A unchanged.
  - SRA by 63 gives all ones if `A[63]`=1, otherwise all zeros.
- Reset (asynchronous, at any time, including mid-SHIFT or DONE):
  - state goes to IDLE, the counter and working register clear, and any in-flight transaction is discarded with no output;
  - output reset values: `in_ready`=1, `out_valid`=0, `Y`=0.

## Timing
- Accept at rising edge T (`in_valid && in_ready` sampled high).
- Stages 0-5 apply at edges T+1 through T+6.
- `out_valid` rises after edge T+6, giving a latency of 6 cycles from accept to valid.
- With `out_ready` held high, DONE lasts 1 cycle. IDLE is entered after edge T+7 and the next accept can occur at edge T+8, so maximum throughput is 1 operation per 8 cycles.
- `in_ready` is low from after edge T until IDLE is re-entered.
- No combinational path exists from `in_valid` or `out_ready` to `Y`. Both handshake outputs are decoded from state only.

## Test plan
- SRL with A=0x8000_0000_0000_00F0, B=4, arith=0 -> `out_valid` 6 cycles after accept, `Y`=0x0800_0000_0000_000F.
- SRA with A=0x8000_0000_0000_0000, B=63, arith=1 -> `Y`=0xFFFF_FFFF_FFFF_FFFF. The same operand with arith=0 -> `Y`=0x0000_0000_0000_0001.
- B=0x40 (upper bits set, low 6 bits 0), A=0x1234_5678_9ABC_DEF0 -> `Y`=A, and latency is still 6.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid`, and change `A`/`B` during the operation -> `Y` stays stable and `in_ready` stays 0. Releasing `out_ready` gives one handoff, then `in_ready`=1 on the next cycle.
- Reset mid-SHIFT: pull `rst_n` low 3 cycles after accept -> `out_valid`=0, `Y`=0, `in_ready`=1 immediately. After release, a new operand (A=0xF0, B=4, SRL) yields `Y`=0xF with normal latency.
- Back-to-back: 100 random (A, B[5:0], arith) operands with `in_valid` held high -> every result matches the reference model, and accepts are spaced exactly 8 cycles apart.
